l3_2way_cache_8kb: RTL and testbench

Level-3 cache directly downstream of the L2 4-way cache. It services L2 miss and fill requests and returns a full 32-bit word via l3_cache_valid_o / l3_cache_data_o, which the L2 consumes for its line fill. L3 misses are fetched from main memory over a req/ack handshake. The cache is 2-way set-associative, write-allocate and write-through, with 1-bit LRU per set.

---
 rtl/l3_cache_pkg.sv | 32 +++
 rtl/l3_tag_store.sv | 61 ++++++
 rtl/l3_2way_cache_8kb.sv | 155 +++++++++++++++
 tb/tb_l3_2way_cache_8kb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l3_cache_pkg.sv
// Shared types, geometry and byte-lane merge helpers for the L3 2-way cache.
package l3_cache_pkg;

  localparam int TAG_BITS   = 22;
  localparam int INDEX_BITS = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } l3_state_t;

  // Only byte, half and word enables modify data; any other pattern leaves the word alone.
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wr,
                                             input logic [3:0] byte_en);
    logic [31:0] res;
    case (byte_en)
      4'b0001: res = {old[31:8], wr[7:0]};
      4'b0011: res = {old[31:16], wr[15:0]};
      4'b1111: res = wr;
      default: res = old;
    endcase
    return res;
  endfunction

  function automatic logic merge_legal(input logic [3:0] byte_en);
    return (byte_en == 4'b0001) || (byte_en == 4'b0011) || (byte_en == 4'b1111);
  endfunction

endpackage

// File: rtl/l3_tag_store.sv
// Valid/tag/LRU state for the 2-way L3: hit detection and victim selection.
module l3_tag_store
  import l3_cache_pkg::*;
#(
  parameter int NUM_SETS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic                  update,
  input  logic                  install,
  input  logic                  upd_way,
  output logic                  hit,
  output logic                  hit_way,
  output logic                  victim_way
);

  logic [NUM_SETS-1:0] valid0_r;
  logic [NUM_SETS-1:0] valid1_r;
  logic [NUM_SETS-1:0] lru_r;
  logic [TAG_BITS-1:0] tag0_r [NUM_SETS];
  logic [TAG_BITS-1:0] tag1_r [NUM_SETS];
  logic                hit0_s;
  logic                hit1_s;

  // Tag compare and replacement choice; an empty way always wins over LRU
  always_comb begin
    hit0_s  = valid0_r[index] && (tag0_r[index] == tag);
    hit1_s  = valid1_r[index] && (tag1_r[index] == tag);
    hit     = hit0_s || hit1_s;
    hit_way = hit1_s;
    if (!valid0_r[index]) begin
      victim_way = 1'b0;
    end else if (!valid1_r[index]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru_r[index];
    end
  end

  // Valid and LRU bits; LRU always points away from the way just used
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_r <= {NUM_SETS{1'b0}};
      valid1_r <= {NUM_SETS{1'b0}};
      lru_r    <= {NUM_SETS{1'b0}};
    end else begin
      if (install && !upd_way) valid0_r[index] <= 1'b1;
      if (install && upd_way)  valid1_r[index] <= 1'b1;
      if (update)              lru_r[index]    <= ~upd_way;
    end
  end

  // Tag arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (install && !upd_way) tag0_r[index] <= tag;
    if (install && upd_way)  tag1_r[index] <= tag;
  end

endmodule

// File: rtl/l3_2way_cache_8kb.sv
// 2-way set-associative, write-allocate, write-through L3 serving L2 requests,
// with misses and write-throughs carried over a req/ack memory handshake.
module l3_2way_cache_8kb
  import l3_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 1024,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [3:0]            byte_en_i,
  output logic                  l3_cache_valid_o,
  output logic [DATA_WIDTH-1:0] l3_cache_data_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  input  logic                  mem_ack_i
);

  l3_state_t             state_r, next_s;
  logic                  wr_en_r;
  logic [DATA_WIDTH-1:0] word_r, word_s;
  logic [DATA_WIDTH-1:0] data_r [NUM_WAYS][NUM_SETS];
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit_s, hit_way_s, victim_s;
  logic                  upd_s, inst_s, upd_way_s, dwr_s, accept_s;

  // The mem_* address/data/byte_en registers double as the latched request
  assign index_s = mem_addr_o[11:2];
  assign tag_s   = {mem_addr_o[31:12], mem_addr_o[1:0]};

  l3_tag_store #(.NUM_SETS(NUM_SETS)) u_tags (
    .clk        (clk),
    .rst        (rst),
    .index      (index_s),
    .tag        (tag_s),
    .update     (upd_s),
    .install    (inst_s),
    .upd_way    (upd_way_s),
    .hit        (hit_s),
    .hit_way    (hit_way_s),
    .victim_way (victim_s)
  );

  // Next-state, response word and array update controls
  always_comb begin
    next_s    = state_r;
    word_s    = word_r;
    upd_s     = 1'b0;
    inst_s    = 1'b0;
    upd_way_s = 1'b0;
    dwr_s     = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i && (byte_en_i != 4'b0000)) begin
          next_s   = LOOKUP;
          accept_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          upd_s     = 1'b1;
          upd_way_s = hit_way_s;
          if (wr_en_r) begin
            word_s = byte_merge(data_r[hit_way_s][index_s], mem_wr_data_o, mem_byte_en_o);
            dwr_s  = 1'b1;
            next_s = merge_legal(mem_byte_en_o) ? MEM_WR : RESP;
          end else begin
            word_s = data_r[hit_way_s][index_s];
            next_s = RESP;
          end
        end else begin
          next_s = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack_i) begin
          upd_s     = 1'b1;
          inst_s    = 1'b1;
          upd_way_s = victim_s;
          dwr_s     = 1'b1;
          if (wr_en_r) begin
            word_s = byte_merge(mem_rd_data_i, mem_wr_data_o, mem_byte_en_o);
            next_s = merge_legal(mem_byte_en_o) ? MEM_WR : RESP;
          end else begin
            word_s = mem_rd_data_i;
            next_s = RESP;
          end
        end else begin
          next_s = MEM_RD;
        end
      end
      MEM_WR: begin
        if (mem_ack_i) begin
          next_s = RESP;
        end else begin
          next_s = MEM_WR;
        end
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Data array write port
  always_ff @(posedge clk) begin
    if (!rst && dwr_s) data_r[upd_way_s][index_s] <= word_s;
  end

  // State, request latch and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      word_r           <= {DATA_WIDTH{1'b0}};
      wr_en_r          <= 1'b0;
      busy_o           <= 1'b0;
      l3_cache_valid_o <= 1'b0;
      l3_cache_data_o  <= {DATA_WIDTH{1'b0}};
      mem_req_o        <= 1'b0;
      mem_wr_en_o      <= 1'b0;
      mem_addr_o       <= {ADDR_WIDTH{1'b0}};
      mem_wr_data_o    <= {DATA_WIDTH{1'b0}};
      mem_byte_en_o    <= 4'b0000;
    end else begin
      state_r          <= next_s;
      word_r           <= word_s;
      busy_o           <= (next_s != IDLE);
      l3_cache_valid_o <= (next_s == RESP);
      l3_cache_data_o  <= (next_s == RESP) ? word_s : {DATA_WIDTH{1'b0}};
      mem_req_o        <= (next_s == MEM_RD) || (next_s == MEM_WR);
      mem_wr_en_o      <= (next_s == MEM_WR);
      if (accept_s) begin
        wr_en_r       <= wr_en_i;
        mem_addr_o    <= addr_i;
        mem_wr_data_o <= wr_data_i;
        mem_byte_en_o <= byte_en_i;
      end
    end
  end

endmodule

// File: tb/tb_l3_2way_cache_8kb.sv
// Directed bench for the L3 cache: recency-list cache model, memory responder
// and a per-cycle response monitor, plus literal checks on key transactions.
module tb_l3_2way_cache_8kb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wr_data_i = 32'h0;
  logic [3:0]  byte_en_i = 4'b0000;
  logic        l3_cache_valid_o;
  logic [31:0] l3_cache_data_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_byte_en_o;
  logic [31:0] mem_rd_data_i = 32'h0;
  logic        mem_ack_i = 1'b0;

  l3_2way_cache_8kb dut (
    .clk(clk), .rst(rst), .req_i(req_i), .wr_en_i(wr_en_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .byte_en_i(byte_en_i), .l3_cache_valid_o(l3_cache_valid_o),
    .l3_cache_data_o(l3_cache_data_o), .busy_o(busy_o), .mem_req_o(mem_req_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_byte_en_o(mem_byte_en_o), .mem_rd_data_i(mem_rd_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } mop_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  mop_t        exp_ops[$];
  mop_t        cur_op;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] cdata [logic [31:0]];
  logic [31:0] mru_a [1024];
  logic [31:0] lru_a [1024];
  int          n_in [1024];
  int          mem_k = 0;
  int          ops_cnt = 0;
  logic        pending = 1'b0;
  int          exp_cyc = 0;
  logic [31:0] exp_data = 32'h0;
  int          acc_cyc = 0;
  int          got_lat = -1;
  logic [31:0] got_data = 32'h0;
  logic        in_op = 1'b0;
  int          cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wr,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    if (be == 4'b0001 || be == 4'b0011 || be == 4'b1111) begin
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wr[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 1024; s++) n_in[s] = 0;
    cdata.delete();
    exp_ops.delete();
  endtask

  // Cache as up to two addresses per set in recency order (index = addr[11:2])
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input int k,
                              output int lat, output logic [31:0] word);
    int   s;
    logic legal, hit;
    s     = int'(addr[11:2]);
    legal = (be == 4'b0001 || be == 4'b0011 || be == 4'b1111);
    hit   = (n_in[s] >= 1 && mru_a[s] == addr) || (n_in[s] == 2 && lru_a[s] == addr);
    if (hit) begin
      word = cdata[addr];
      if (wr) word = lane_merge(word, data, be);
      cdata[addr] = word;
      if (n_in[s] == 2 && lru_a[s] == addr) begin
        lru_a[s] = mru_a[s];
        mru_a[s] = addr;
      end
      lat = 2;
      if (wr && legal) begin
        exp_ops.push_back('{wr: 1'b1, addr: addr, data: data, be: be});
        lat = 3 + k;
      end
    end else begin
      exp_ops.push_back('{wr: 1'b0, addr: addr, data: data, be: be});
      word = mem_word(addr);
      if (wr) word = lane_merge(word, data, be);
      lat = 3 + k;
      if (wr && legal) begin
        exp_ops.push_back('{wr: 1'b1, addr: addr, data: data, be: be});
        lat = lat + 1 + k;
      end
      if (n_in[s] == 2) begin
        cdata.delete(lru_a[s]);
        lru_a[s] = mru_a[s];
      end else if (n_in[s] == 1) begin
        lru_a[s] = mru_a[s];
        n_in[s]  = 2;
      end else begin
        n_in[s] = 1;
      end
      mru_a[s]    = addr;
      cdata[addr] = word;
    end
  endtask

  // Memory responder: checks each operation, acks mem_k cycles after it starts
  initial begin
    forever begin
      @(negedge clk);
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        in_op     = 1'b0;
      end
      if (in_op && !mem_req_o) in_op = 1'b0;
      if (mem_req_o && !in_op) begin
        in_op = 1'b1;
        cnt   = mem_k;
        ops_cnt++;
        if (exp_ops.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mem_unexpected: got req addr %h wr %b, want no request", mem_addr_o, mem_wr_en_o);
        end else begin
          cur_op = exp_ops.pop_front();
          check("mem_addr", mem_addr_o, cur_op.addr);
          check("mem_wr_en", {31'b0, mem_wr_en_o}, {31'b0, cur_op.wr});
          if (cur_op.wr) begin
            check("mem_wr_data", mem_wr_data_o, cur_op.data);
            check("mem_byte_en", {28'b0, mem_byte_en_o}, {28'b0, cur_op.be});
          end
        end
      end
      if (in_op && !mem_ack_i) begin
        if (cnt == 0) begin
          mem_ack_i = 1'b1;
          if (mem_wr_en_o) begin
            mem_model[mem_addr_o] = lane_merge(mem_word(mem_addr_o), mem_wr_data_o, mem_byte_en_o);
          end else begin
            mem_rd_data_i = mem_word(mem_addr_o);
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Response monitor: valid/data must match the model on every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pending && cyc == exp_cyc) begin
          check("resp_valid", {31'b0, l3_cache_valid_o}, 32'd1);
          check("resp_data", l3_cache_data_o, exp_data);
        end else begin
          check("quiet_valid", {31'b0, l3_cache_valid_o}, 32'd0);
          check("quiet_data", l3_cache_data_o, 32'd0);
        end
        if (l3_cache_valid_o) begin
          got_lat  = cyc - acc_cyc;
          got_data = l3_cache_data_o;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int k);
    int          lat;
    logic [31:0] w;
    @(negedge clk);
    mem_k    = k;
    ops_cnt  = 0;
    got_lat  = -1;
    got_data = 32'h0;
    model_access(wr, addr, data, be, k, lat, w);
    req_i     = 1'b1;
    wr_en_i   = wr;
    addr_i    = addr;
    wr_data_i = data;
    byte_en_i = be;
    acc_cyc   = cyc;
    exp_cyc   = cyc + lat;
    exp_data  = w;
    pending   = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    while (cyc <= exp_cyc) @(negedge clk);
    check("busy_after_resp", {31'b0, busy_o}, 32'd0);
    pending = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, want finish before 300000");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, l3_cache_valid_o}, 32'd0);
    check("rst_data", l3_cache_data_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mem_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wr_data_o, 32'd0);
    check("rst_mem_be", {28'b0, mem_byte_en_o}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: cold read miss, ack 3 cycles after mem_req rises
    mem_model[32'h0000_1004] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 3);
    check("t1_data", got_data, 32'hDEAD_BEEF);
    check("t1_lat", got_lat, 32'd6);
    check("t1_ops", ops_cnt, 32'd1);

    // 2: read hit
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0);
    check("t2_data", got_data, 32'hDEAD_BEEF);
    check("t2_lat", got_lat, 32'd2);
    check("t2_ops", ops_cnt, 32'd0);

    // 3: byte write hit, then read back
    do_req(1'b1, 32'h0000_1004, 32'h0000_00AA, 4'b0001, 1);
    check("t3_data", got_data, 32'hDEAD_BEAA);
    check("t3_lat", got_lat, 32'd4);
    check("t3_ops", ops_cnt, 32'd1);
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0);
    check("t3_readback", got_data, 32'hDEAD_BEAA);

    // 4: three addresses in set 1; 0x1004 is evicted, 0x2004 stays
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0);
    do_req(1'b0, 32'h0000_2004, 32'h0, 4'b1111, 0);
    check("t4_2004_data", got_data, 32'h5A5A_2004);
    do_req(1'b0, 32'h0000_3004, 32'h0, 4'b1111, 2);
    check("t4_3004_lat", got_lat, 32'd5);
    do_req(1'b0, 32'h0000_2004, 32'h0, 4'b1111, 0);
    check("t4_2004_hit_ops", ops_cnt, 32'd0);
    check("t4_2004_hit_lat", got_lat, 32'd2);
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0);
    check("t4_1004_miss_ops", ops_cnt, 32'd1);

    // 5: half write miss, then a non-mergeable enable on the now-resident line
    mem_model[32'h0000_5008] = 32'h1111_2222;
    do_req(1'b1, 32'h0000_5008, 32'h0000_1234, 4'b0011, 1);
    check("t5_data", got_data, 32'h1111_1234);
    check("t5_lat", got_lat, 32'd6);
    check("t5_ops", ops_cnt, 32'd2);
    do_req(1'b1, 32'h0000_5008, 32'hFFFF_FFFF, 4'b0101, 0);
    check("t5_odd_be_data", got_data, 32'h1111_1234);
    check("t5_odd_be_ops", ops_cnt, 32'd0);

    // Requests with no byte enables are ignored
    @(negedge clk);
    ops_cnt   = 0;
    req_i     = 1'b1;
    byte_en_i = 4'b0000;
    repeat (3) @(negedge clk);
    req_i = 1'b0;
    check("zero_be_busy", {31'b0, busy_o}, 32'd0);
    check("zero_be_ops", ops_cnt, 32'd0);

    // 6: reset while waiting for a read fill
    @(negedge clk);
    mem_k     = 10;
    ops_cnt   = 0;
    exp_ops.push_back('{wr: 1'b0, addr: 32'h0000_7004, data: 32'h0, be: 4'b1111});
    req_i     = 1'b1;
    wr_en_i   = 1'b0;
    addr_i    = 32'h0000_7004;
    byte_en_i = 4'b1111;
    @(posedge clk);
    #1 req_i = 1'b0;
    for (int i = 0; i < 8 && !mem_req_o; i++) @(negedge clk);
    check("t6_mem_req_up", {31'b0, mem_req_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_mem_req_drop", {31'b0, mem_req_o}, 32'd0);
    check("t6_busy_drop", {31'b0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("t6_mem_req_quiet", {31'b0, mem_req_o}, 32'd0);
    do_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 0);
    check("t6_refetch_ops", ops_cnt, 32'd1);
    check("t6_refetch_lat", got_lat, 32'd3);
    check("t6_refetch_data", got_data, 32'hDEAD_BEAA);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
